// File: rtl/xmint_data_mem_resp.sv
// xmint_data_mem_resp: req/gnt/rvalid data memory responder.
// Word RAM with grant wait states, byte writes and range errors.
module xmint_data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned GNT_WAIT    = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o,
  input  logic        stall_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR =
    LO_ADDR + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0] WAIT_MAX = 4'(GNT_WAIT);

  logic [3:0]       wait_q;
  logic [3:0]       wait_d;
  logic             rvalid_q;
  logic             rvalid_d;
  logic             err_q;
  logic             err_d;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;

  logic [31:0]      ram [DEPTH_WORDS];

  logic [31:0]      offs;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             gnt;
  logic             accept;
  logic             wr_en;
  logic [31:0]      rd_word;
  logic             unused_bits;

  // Grant only once the request has waited long enough.
  assign gnt = req_i && !stall_i && !rst_i &&
               (wait_q == WAIT_MAX);
  assign accept = req_i && gnt;

  // Address decode; 33-bit compare keeps the top bound from wrapping.
  always_comb begin
    offs     = addr_i - BASE_ADDR;
    idx      = offs[IDX_W+1:2];
    in_range = ({1'b0, addr_i} >= LO_ADDR) &&
               ({1'b0, addr_i} < HI_ADDR);
    wr_en    = accept && we_i && in_range;
    rd_word  = ram[idx];
  end

  // Grant wait counter: counts unstalled waiting cycles.
  always_comb begin
    wait_d = wait_q;
    if (!req_i || accept) begin
      wait_d = '0;
    end else if (!stall_i && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Response next state; data and error hold between responses.
  always_comb begin
    rvalid_d = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    if (accept) begin
      rvalid_d = 1'b1;
      err_d    = !in_range;
      rdata_d  = (!we_i && in_range) ? rd_word : '0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Byte-enable RAM write at the accepting edge; never cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          ram[idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign rdata_intg_o = 7'b0;

  assign unused_bits = ^{wdata_intg_i,
                         offs[31:IDX_W+2],
                         offs[1:0]};

endmodule

// File: tb/tb_xmint_data_mem_resp.sv
// tb_xmint_data_mem_resp: directed bench with a reference model.
// Two responders: no wait states and three wait states.
module tb_xmint_data_mem_resp;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic        stall [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic        err   [2];
  logic [31:0] rdata [2];
  logic [6:0]  rintg [2];

  int total = 0;
  int bad   = 0;

  xmint_data_mem_resp #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_WAIT(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
    .rvalid_o(rvalid[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .wdata_intg_i(7'h55),
    .rdata_o(rdata[0]), .rdata_intg_o(rintg[0]), .err_o(err[0]),
    .stall_i(stall[0])
  );

  xmint_data_mem_resp #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_WAIT(3)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
    .rvalid_o(rvalid[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .wdata_intg_i(7'h2a),
    .rdata_o(rdata[1]), .rdata_intg_o(rintg[1]), .err_o(err[1]),
    .stall_i(stall[1])
  );

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Reference model: grant after gw unstalled waiting cycles,
  // response one cycle after each grant, sparse word memory.
  int          gw [2];
  int          waited [2];
  bit          exp_rv [2];
  bit          exp_err [2];
  bit [31:0]   exp_rd [2];
  bit [31:0]   mm [longint];
  bit          chk_en;

  initial begin
    bit        eg;
    bit        inr;
    longint    a;
    longint    key;
    bit [31:0] w;
    gw[0] = 0;
    gw[1] = 3;
    chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      waited[d] = 0;
      exp_rv[d] = 1'b0;
      exp_err[d] = 1'b0;
      exp_rd[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        eg = req[d] && !stall[d] && !rst && (waited[d] >= gw[d]);
        if (chk_en) begin
          check($sformatf("gnt%0d", d), gnt[d], eg);
          check($sformatf("rvalid%0d", d), rvalid[d], exp_rv[d]);
          check($sformatf("err%0d", d), err[d], exp_err[d]);
          check($sformatf("rdata%0d", d), rdata[d], exp_rd[d]);
          check($sformatf("rintg%0d", d), rintg[d], 0);
        end
        if (rst) begin
          waited[d]  = 0;
          exp_rv[d]  = 1'b0;
          exp_err[d] = 1'b0;
          exp_rd[d]  = '0;
        end else begin
          if (!req[d] || eg) waited[d] = 0;
          else if (!stall[d]) waited[d]++;
          exp_rv[d] = 1'b0;
          if (eg) begin
            a   = addr[d];
            inr = (a >= longint'(BASE)) &&
                  (a < longint'(BASE) + DEPTH * 4);
            exp_rv[d]  = 1'b1;
            exp_err[d] = !inr;
            exp_rd[d]  = '0;
            if (inr) begin
              key = longint'(d) * 1000000 + (a - longint'(BASE)) / 4;
              w = mm.exists(key) ? mm[key] : 32'h0;
              if (we[d]) begin
                for (int i = 0; i < 4; i++)
                  if (be[d][i]) w[8*i +: 8] = wdata[d][8*i +: 8];
                mm[key] = w;
              end else begin
                exp_rd[d] = w;
              end
            end
          end
        end
      end
      if (rst) chk_en = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One transfer: hold req until granted, return wait count
  // and the response; ends one cycle after the response.
  task automatic xfer(input int d, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e,
                      output int n);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    n = 0;
    @(negedge clk);
    while (!gnt[d] && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (!gnt[d]) begin
      bad++;
      $display("FAIL grant_timeout%0d got=0 want=1", d);
    end
    cyc();
    req[d] = 1'b0;
    @(negedge clk);
    check("xfer_rvalid", rvalid[d], 1);
    rd = rdata[d];
    e  = err[d];
    cyc();
  endtask

  task automatic wait_run(input bit with_stall,
                          output logic [7:0] gb, output logic [7:0] vb);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = BASE + 32'h40;
    be[1] = 4'hF; wdata[1] = 32'h3C3C_3C3C; stall[1] = 1'b0;
    gb = '0;
    vb = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      gb[c] = gnt[1];
      vb[c] = rvalid[1];
      cyc();
      if (gb[c]) req[1] = 1'b0;
      stall[1] = with_stall && (c + 1 == 1 || c + 1 == 2);
    end
    stall[1] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        e;
  int          n;
  logic [7:0]  gb;
  logic [7:0]  vb;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; stall[d] = 1'b0;
      be[d] = '0; addr[d] = BASE; wdata[d] = '0;
    end
    cyc();
    req[0] = 1'b1;
    @(negedge clk);
    check("rst_blocks_gnt", gnt[0], 0);
    cyc();
    rst = 1'b0;
    req[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_gnt", gnt[0], 0);
      check("idle_rvalid", rvalid[0], 0);
      check("idle_err", err[0], 0);
      check("idle_rdata", rdata[0], 0);
      cyc();
    end

    xfer(0, 1, 32'h0010_0010, 4'hF, 32'hCAFE_BABE, rd, e, n);
    check("w_gnt_latency", n, 0);
    check("w_err", e, 0);
    check("w_rdata", rd, 0);
    xfer(0, 0, 32'h0010_0010, 4'h0, 32'h0, rd, e, n);
    check("r_data", rd, 32'hCAFE_BABE);
    xfer(0, 0, 32'h0010_0013, 4'h1, 32'h0, rd, e, n);
    check("r_low_bits_ignored", rd, 32'hCAFE_BABE);

    xfer(0, 1, 32'h0010_0020, 4'hF, 32'hDEAD_BEEF, rd, e, n);
    xfer(0, 1, 32'h0010_0020, 4'b0101, 32'h1122_3344, rd, e, n);
    xfer(0, 0, 32'h0010_0020, 4'hF, 32'h0, rd, e, n);
    check("be_merge", rd, 32'hDE22_BE44);
    xfer(0, 1, 32'h0010_0020, 4'h0, 32'hFFFF_FFFF, rd, e, n);
    check("be_zero_err", e, 0);
    xfer(0, 0, 32'h0010_0020, 4'hF, 32'h0, rd, e, n);
    check("be_zero_keep", rd, 32'hDE22_BE44);

    xfer(0, 1, BASE, 4'hF, 32'h0BAD_F00D, rd, e, n);
    xfer(0, 1, 32'h0000_0000, 4'hF, 32'h1234_5678, rd, e, n);
    check("oor_w_err", e, 1);
    check("oor_w_rdata", rd, 0);
    xfer(0, 0, BASE + DEPTH * 4, 4'hF, 32'h0, rd, e, n);
    check("oor_r_err", e, 1);
    check("oor_r_rdata", rd, 0);
    xfer(0, 0, BASE, 4'hF, 32'h0, rd, e, n);
    check("word0_kept", rd, 32'h0BAD_F00D);
    xfer(0, 1, BASE + DEPTH * 4 - 4, 4'hF, 32'h5A5A_A5A5, rd, e, n);
    xfer(0, 0, BASE + DEPTH * 4 - 4, 4'hF, 32'h0, rd, e, n);
    check("top_word_err", e, 0);
    check("top_word", rd, 32'h5A5A_A5A5);

    for (int i = 0; i < 4; i++)
      xfer(0, 1, BASE + 32'h100 + 4 * i, 4'hF,
           32'hA000_0000 + i, rd, e, n);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_gnt", gnt[0], 1);
      if (i > 0) begin
        check("b2b_rvalid", rvalid[0], 1);
        check("b2b_rdata", rdata[0], 32'hA000_0000 + i - 1);
      end
      cyc();
      addr[0] = BASE + 32'h100 + 4 * (i + 1);
      if (i == 3) req[0] = 1'b0;
    end
    @(negedge clk);
    check("b2b_rvalid_last", rvalid[0], 1);
    check("b2b_rdata_last", rdata[0], 32'hA000_0003);
    cyc();

    req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'h200;
    be[0] = 4'hF; wdata[0] = 32'h600D_D00D;
    @(negedge clk);
    check("mid_gnt", gnt[0], 1);
    cyc();
    rst = 1'b1;
    we[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_gnt", gnt[0], 0);
    cyc();
    rst = 1'b0;
    req[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_rvalid", rvalid[0], 0);
      cyc();
    end
    xfer(0, 0, BASE + 32'h200, 4'hF, 32'h0, rd, e, n);
    check("mid_write_done", rd, 32'h600D_D00D);

    wait_run(1'b0, gb, vb);
    check("ws_gnt_pattern", gb, 8'b0000_1000);
    check("ws_rv_pattern", vb, 8'b0001_0000);
    wait_run(1'b1, gb, vb);
    check("ws_stall_gnt", gb, 8'b0010_0000);
    check("ws_stall_rv", vb, 8'b0100_0000);
    xfer(1, 0, BASE + 32'h40, 4'hF, 32'h0, rd, e, n);
    check("ws_wait_count", n, 3);
    check("ws_rdata", rd, 32'h3C3C_3C3C);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
